// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with a single outstanding line refill
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset (0 = reset)
//   rdy                      global enable; 0 freezes fetcher-side sampling
//   addr_from_fetcher        instruction byte address (bits [1:0] ignored)
//   valid_from_fetcher       fetch request, held stable until ready_to_fetcher
//   inst_to_fetcher          returned word, valid while ready_to_fetcher=1
//   ready_to_fetcher         one-cycle response pulse
//   addr_to_mem              line-aligned refill address
//   valid_to_mem             refill request level
//   data_from_mem            128-bit refill line, little-endian words
//   ready_from_mem           one-cycle pulse qualifying data_from_mem
//   flush                    (only with ICACHE_FLUSH_EN) clears all valid bits
module icache #(
    parameter int LINES      = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic [31:0]  addr_from_fetcher,
    input  logic         valid_from_fetcher,
`ifdef ICACHE_FLUSH_EN
    input  logic         flush,
`endif
    output logic [31:0]  inst_to_fetcher,
    output logic         ready_to_fetcher,
    output logic [31:0]  addr_to_mem,
    output logic         valid_to_mem,
    input  logic [127:0] data_from_mem,
    input  logic         ready_from_mem
);
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state, state_nx;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [127:0]          data [LINES];
    logic                  pend, sq;
    logic [1:0]            w_sel;
    logic [INDEX_BITS-1:0] idx, fill_idx;
    logic [TAG_BITS-1:0]   tag;
    logic [127:0]          line;
    logic                  flush_now, accept, hit, fill, respond;
    logic                  unused;

`ifdef ICACHE_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign idx      = addr_from_fetcher[INDEX_BITS+3:4];
    assign tag      = addr_from_fetcher[31:INDEX_BITS+4];
    assign fill_idx = addr_to_mem[INDEX_BITS+3:4];
    assign line     = data[idx];
    assign unused   = ^addr_from_fetcher[1:0];

    // pend marks a completed refill whose response waits for rdy; sq marks a
    // refill the fetcher abandoned, so it installs without a response pulse.
    always_comb begin
        accept   = state == IDLE && rdy && valid_from_fetcher && !ready_to_fetcher && !pend;
        hit      = valid[idx] && tags[idx] == tag && !flush_now;
        fill     = state == MISS && ready_from_mem;
        respond  = !sq && !(rdy && !valid_from_fetcher);
        state_nx = fill ? IDLE : (accept && !hit) ? MISS : state;
    end

    always_ff @(posedge clk) begin
        state <= !rst ? IDLE : state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst && fill) begin
            tags[fill_idx] <= addr_to_mem[31:INDEX_BITS+4];
            data[fill_idx] <= data_from_mem;
        end
    end

    always_ff @(posedge clk) begin
        ready_to_fetcher <= 1'b0;
        if (!rst) begin
            valid           <= '0;
            inst_to_fetcher <= '0;
            addr_to_mem     <= '0;
            valid_to_mem    <= 1'b0;
            pend            <= 1'b0;
            sq              <= 1'b0;
            w_sel           <= '0;
        end else begin
            if (flush_now)
                valid <= '0;
            // the refilled index survives a coincident flush: its data is fresh
            if (fill) begin
                valid[fill_idx]  <= 1'b1;
                valid_to_mem     <= 1'b0;
                inst_to_fetcher  <= data_from_mem[{w_sel, 5'b0} +: 32];
                ready_to_fetcher <= respond && rdy;
                pend             <= respond && !rdy;
            end else if (state == MISS && rdy && !valid_from_fetcher)
                sq <= 1'b1;
            if (pend && rdy) begin
                ready_to_fetcher <= 1'b1;
                pend             <= 1'b0;
            end
            if (accept && hit) begin
                ready_to_fetcher <= 1'b1;
                inst_to_fetcher  <= line[{addr_from_fetcher[3:2], 5'b0} +: 32];
            end
            if (accept && !hit) begin
                valid_to_mem <= 1'b1;
                addr_to_mem  <= {addr_from_fetcher[31:4], 4'b0};
                w_sel        <= addr_from_fetcher[3:2];
                sq           <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache against a line-level memory and cache model
module tb_icache;
    logic         clk = 0;
    logic         rst = 0;
    logic         rdy = 1;
    logic [31:0]  addr_from_fetcher = 0;
    logic         valid_from_fetcher = 0;
    logic [31:0]  inst_to_fetcher;
    logic         ready_to_fetcher;
    logic [31:0]  addr_to_mem;
    logic         valid_to_mem;
    logic [127:0] data_from_mem = 0;
    logic         ready_from_mem = 0;
`ifdef ICACHE_FLUSH_EN
    logic         flush = 0;
`endif

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .addr_from_fetcher(addr_from_fetcher),
        .valid_from_fetcher(valid_from_fetcher),
`ifdef ICACHE_FLUSH_EN
        .flush(flush),
`endif
        .inst_to_fetcher(inst_to_fetcher),
        .ready_to_fetcher(ready_to_fetcher),
        .addr_to_mem(addr_to_mem),
        .valid_to_mem(valid_to_mem),
        .data_from_mem(data_from_mem),
        .ready_from_mem(ready_from_mem)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    bit          mv[16];
    logic [23:0] mt[16];

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    // Backing memory: line 0x1000 holds the test-plan words, others a hash of the address.
    function automatic logic [127:0] line_of(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++)
            l[32*k +: 32] = (la == 32'h1000) ? 32'h11111111 * 32'(k + 1)
                          : (la + 32'(4 * k)) * 32'h9E3779B1 ^ 32'hA5A50000;
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [127:0] l;
        l = line_of({a[31:4], 4'b0});
        return l[32*int'(a[3:2]) +: 32];
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 16; k++) mv[k] = 0;
    endfunction

    always @(negedge clk) begin
        if (ready_to_fetcher) begin
            if (exp_q.size() == 0)
                check("unexpected_pulse", 32'd1, 32'd0);
            else
                check("inst", inst_to_fetcher, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 normal, 1 squash during refill, 2 rdy low while refill returns
    task automatic fetch(input logic [31:0] a, input int mode, input int stall);
        int  i = int'(a[7:4]);
        bit  h = mv[i] && mt[i] == a[31:8];
        int  lat = $urandom_range(0, 3);
        if (h || mode != 1) exp_q.push_back(word_of(a));
        addr_from_fetcher = a;
        valid_from_fetcher = 1;
        if (stall > 0) begin
            rdy = 0;
            repeat (stall) begin
                tick();
                check("stall_no_mem", 32'(valid_to_mem), 0);
                check("stall_no_rdy", 32'(ready_to_fetcher), 0);
            end
            rdy = 1;
        end
        tick();
        if (h) begin
            check("hit_pulse", 32'(ready_to_fetcher), 1);
            check("hit_no_mem", 32'(valid_to_mem), 0);
        end else begin
            check("miss_req", 32'(valid_to_mem), 1);
            check("miss_addr", addr_to_mem, {a[31:4], 4'b0});
            check("miss_no_rdy", 32'(ready_to_fetcher), 0);
            repeat (lat) begin
                tick();
                check("miss_hold", 32'(valid_to_mem), 1);
                check("miss_hold_addr", addr_to_mem, {a[31:4], 4'b0});
            end
            if (mode == 1) valid_from_fetcher = 0;
            if (mode == 2) rdy = 0;
            ready_from_mem = 1;
            data_from_mem = line_of({a[31:4], 4'b0});
            tick();
            ready_from_mem = 0;
            data_from_mem = '0;
            check("mem_drop", 32'(valid_to_mem), 0);
            check("fill_pulse", 32'(ready_to_fetcher), mode == 0 ? 1 : 0);
            if (mode == 2) begin
                tick();
                check("defer_hold", 32'(ready_to_fetcher), 0);
                rdy = 1;
                tick();
                check("defer_pulse", 32'(ready_to_fetcher), 1);
            end
            mv[i] = 1;
            mt[i] = a[31:8];
        end
        valid_from_fetcher = 0;
        tick();
        check("pulse_single", 32'(ready_to_fetcher), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        tick();
        tick();
        check("rst_ready", 32'(ready_to_fetcher), 0);
        check("rst_vmem", 32'(valid_to_mem), 0);
        check("rst_inst", inst_to_fetcher, 0);
        check("rst_amem", addr_to_mem, 0);
        rst = 1;
        tick();

        fetch(32'h00001004, 0, 0);
        fetch(32'h0000100C, 0, 0);
        fetch(32'h00002004, 0, 0);
        fetch(32'h00001004, 0, 0);
        fetch(32'h00003010, 1, 0);
        fetch(32'h00003010, 0, 0);
        fetch(32'h00004020, 2, 0);
        fetch(32'h00004024, 0, 1);

        // reset while a refill is pending; the late memory pulse must not install
        addr_from_fetcher = 32'h00005040;
        valid_from_fetcher = 1;
        tick();
        tick();
        check("rm_req", 32'(valid_to_mem), 1);
        rst = 0;
        valid_from_fetcher = 0;
        tick();
        rst = 1;
        model_clear();
        check("rm_vmem", 32'(valid_to_mem), 0);
        check("rm_amem", addr_to_mem, 0);
        ready_from_mem = 1;
        data_from_mem = line_of(32'h00005040);
        tick();
        ready_from_mem = 0;
        check("rm_ignored_rdy", 32'(ready_to_fetcher), 0);
        check("rm_ignored_vmem", 32'(valid_to_mem), 0);
        fetch(32'h00005040, 0, 0);

`ifdef ICACHE_FLUSH_EN
        fetch(32'h00000020, 0, 0);
        fetch(32'h00000024, 0, 0);
        flush = 1;
        tick();
        flush = 0;
        model_clear();
        fetch(32'h00000020, 0, 0);
`endif

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int m;
            a = (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(0, 15)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            m = $urandom_range(0, 5);
            fetch(a, m < 4 ? 0 : m - 3, $urandom_range(0, 3) == 0 ? 2 : 0);
        end

        tick();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
